// File: rtl/mem_arb_defs.sv
// rtl/mem_arb_defs.sv - shared state and port encodings for the data-memory arbiter
package mem_arb_defs;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } arb_state_e;

  localparam logic PORT_PIPE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/mem_data.sv
// rtl/mem_data.sv - single-port synchronous data memory, registered read, not reset
module mem_data #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [p_ADDR_LEN-1:0] i_addr,
  input  logic [p_WORD_LEN-1:0] i_wdata,
  output logic [p_WORD_LEN-1:0] o_rdata
);

  logic [p_WORD_LEN-1:0] r_mem [0:(1<<p_ADDR_LEN)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/mem_data_arb.sv
// rtl/mem_data_arb.sv - two-port round-robin arbiter for the data memory
// Port 0 is the pipeline MEM stage, port 1 the debug/loader; optional zero-fill after reset.
module mem_data_arb
  import mem_arb_defs::*;
#(
  parameter int p_WORD_LEN       = 16,
  parameter int p_ADDR_LEN       = 10,
  parameter int p_CLEAR_ON_RESET = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_we,
  input  logic [p_ADDR_LEN-1:0] i_req0_addr,
  input  logic [p_WORD_LEN-1:0] i_req0_wdata,
  output logic                  o_rsp0_valid,
  output logic [p_WORD_LEN-1:0] o_rsp0_data,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_we,
  input  logic [p_ADDR_LEN-1:0] i_req1_addr,
  input  logic [p_WORD_LEN-1:0] i_req1_wdata,
  output logic                  o_rsp1_valid,
  output logic [p_WORD_LEN-1:0] o_rsp1_data,
  output logic                  o_busy
);

  arb_state_e            r_state;
  logic [p_ADDR_LEN-1:0] r_clr_cnt;
  logic                  r_last;
  logic                  r_rsp0_valid;
  logic                  r_rsp1_valid;
  logic [p_WORD_LEN-1:0] r_rsp0_hold;
  logic [p_WORD_LEN-1:0] r_rsp1_hold;

  logic                  grant0;
  logic                  grant1;
  logic                  mem_we;
  logic [p_ADDR_LEN-1:0] mem_addr;
  logic [p_WORD_LEN-1:0] mem_wdata;
  logic [p_WORD_LEN-1:0] mem_rdata;

  // On a tie the port that was not served last wins.
  assign grant0 = i_req0_valid && (!i_req1_valid || r_last == PORT_DBG);
  assign grant1 = i_req1_valid && (!i_req0_valid || r_last == PORT_PIPE);

  assign o_req0_ready = (r_state == ST_ARB) && !i_rst && grant0;
  assign o_req1_ready = (r_state == ST_ARB) && !i_rst && grant1;
  assign o_busy       = (r_state == ST_CLEAR);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == ST_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = r_clr_cnt;
    end else if (o_req0_ready) begin
      mem_we    = i_req0_we;
      mem_addr  = i_req0_addr;
      mem_wdata = i_req0_wdata;
    end else if (o_req1_ready) begin
      mem_we    = i_req1_we;
      mem_addr  = i_req1_addr;
      mem_wdata = i_req1_wdata;
    end
  end

  mem_data #(
    .p_WORD_LEN(p_WORD_LEN),
    .p_ADDR_LEN(p_ADDR_LEN)
  ) u_mem (
    .i_clk  (i_clk),
    .i_we   (mem_we),
    .i_addr (mem_addr),
    .i_wdata(mem_wdata),
    .o_rdata(mem_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= (p_CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
      r_clr_cnt    <= '0;
      r_last       <= PORT_DBG;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_hold  <= '0;
      r_rsp1_hold  <= '0;
    end else begin
      r_rsp0_valid <= o_req0_ready && !i_req0_we;
      r_rsp1_valid <= o_req1_ready && !i_req1_we;
      // Each port keeps its own copy so the other port's reads cannot overwrite it.
      if (r_rsp0_valid) begin
        r_rsp0_hold <= mem_rdata;
      end
      if (r_rsp1_valid) begin
        r_rsp1_hold <= mem_rdata;
      end
      if (r_state == ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
        if (r_clr_cnt == '1) begin
          r_state <= ST_ARB;
        end
      end else if (o_req0_ready) begin
        r_last <= PORT_PIPE;
      end else if (o_req1_ready) begin
        r_last <= PORT_DBG;
      end
    end
  end

  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp0_data  = r_rsp0_valid ? mem_rdata : r_rsp0_hold;
  assign o_rsp1_data  = r_rsp1_valid ? mem_rdata : r_rsp1_hold;

endmodule

// File: tb/tb_mem_data_arb.sv
// tb/tb_mem_data_arb.sv - self-checking bench for mem_data_arb with a shadow-memory model
module tb_mem_data_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        v0 = 1'b0, we0 = 1'b0, v1 = 1'b0, we1 = 1'b0;
  logic [9:0]  a0 = '0, a1 = '0;
  logic [15:0] wd0 = '0, wd1 = '0;
  logic        rdy0, rdy1, rv0, rv1, busy;
  logic [15:0] rd0, rd1;

  logic        nc_rst = 1'b1;
  logic        nc_v1 = 1'b0;
  logic        nc_rdy0, nc_rdy1, nc_rv0, nc_rv1, nc_busy;
  logic [15:0] nc_rd0, nc_rd1;

  int n_checks = 0;
  int n_errors = 0;

  mem_data_arb #(.p_WORD_LEN(16), .p_ADDR_LEN(10), .p_CLEAR_ON_RESET(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_we(we0), .i_req0_addr(a0),
    .i_req0_wdata(wd0), .o_rsp0_valid(rv0), .o_rsp0_data(rd0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_we(we1), .i_req1_addr(a1),
    .i_req1_wdata(wd1), .o_rsp1_valid(rv1), .o_rsp1_data(rd1),
    .o_busy(busy)
  );

  mem_data_arb #(.p_WORD_LEN(16), .p_ADDR_LEN(10), .p_CLEAR_ON_RESET(0)) dut_nc (
    .i_clk(clk), .i_rst(nc_rst),
    .i_req0_valid(1'b0), .o_req0_ready(nc_rdy0), .i_req0_we(1'b0), .i_req0_addr(10'd0),
    .i_req0_wdata(16'd0), .o_rsp0_valid(nc_rv0), .o_rsp0_data(nc_rd0),
    .i_req1_valid(nc_v1), .o_req1_ready(nc_rdy1), .i_req1_we(1'b0), .i_req1_addr(10'd3),
    .i_req1_wdata(16'd0), .o_rsp1_valid(nc_rv1), .o_rsp1_data(nc_rd1),
    .o_busy(nc_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: shadow memory, clear countdown, round-robin "last served" port.
  logic [15:0] m_mem [0:1023];
  bit          m_init = 0;
  int          m_left = 0;
  bit          m_last = 1;
  bit          m_rv0 = 0, m_rv1 = 0;
  logic [15:0] m_rd0 = '0, m_rd1 = '0;

  always @(negedge clk) begin
    bit e_busy, g0, g1;
    e_busy = (m_left > 0);
    g0 = !e_busy && !rst && v0 && (!v1 || m_last == 1'b1);
    g1 = !e_busy && !rst && v1 && (!v0 || m_last == 1'b0);
    if (m_init) begin
      chk("busy", busy, e_busy);
      chk("ready0", rdy0, g0);
      chk("ready1", rdy1, g1);
      chk("rsp0_valid", rv0, m_rv0);
      chk("rsp1_valid", rv1, m_rv1);
      chk("rsp0_data", rd0, m_rd0);
      chk("rsp1_data", rd1, m_rd1);
    end
    if (rst) begin
      m_init = 1;
      m_left = 1024;
      m_last = 1;
      m_rv0  = 0;
      m_rv1  = 0;
      m_rd0  = '0;
      m_rd1  = '0;
      for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    end else if (m_init) begin
      m_rv0 = 0;
      m_rv1 = 0;
      if (m_left > 0) begin
        m_left--;
      end else if (g0) begin
        m_last = 0;
        if (we0) m_mem[a0] = wd0;
        else begin m_rv0 = 1; m_rd0 = m_mem[a0]; end
      end else if (g1) begin
        m_last = 1;
        if (we1) m_mem[a1] = wd1;
        else begin m_rv1 = 1; m_rd1 = m_mem[a1]; end
      end
    end
  end

  task automatic req(input int port, input logic we, input logic [9:0] addr, input logic [15:0] wd);
    bit done = 0;
    if (port == 0) begin v0 = 1; we0 = we; a0 = addr; wd0 = wd; end
    else           begin v1 = 1; we1 = we; a1 = addr; wd1 = wd; end
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if ((port == 0 && rdy0) || (port == 1 && rdy1)) done = 1;
      @(posedge clk); #1;
    end
    v0 = 0;
    v1 = 0;
    chk("req_accepted", done, 1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1;
    repeat (cycles) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    int n;
    logic [9:0]  sa [3];
    logic [15:0] sd [3];
    sa[0] = 10'h010; sa[1] = 10'h020; sa[2] = 10'h3FF;
    sd[0] = 16'hAAAA; sd[1] = 16'h5555; sd[2] = 16'h1234;

    v0 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 1);
    chk("reset_ready0", rdy0, 0);
    chk("reset_rsp0_valid", rv0, 0);
    chk("reset_rsp0_data", rd0, 16'h0000);
    chk("reset_rsp1_data", rd1, 16'h0000);
    @(posedge clk); #1;
    rst = 0;
    v0 = 0;
    count_busy(n);
    chk("clear_len", n, 1024);

    req(0, 1, 10'd5, 16'hBEEF);
    req(0, 0, 10'd5, 16'h0);
    @(negedge clk);
    chk("preload_valid", rv0, 1);
    chk("preload_data", rd0, 16'hBEEF);
    @(posedge clk); #1;

    // Reset, then reset again mid-clear: the clear must restart in full.
    do_reset(1);
    repeat (500) @(posedge clk);
    #1;
    do_reset(1);
    count_busy(n);
    chk("clear_restart_len", n, 1024);
    req(0, 0, 10'd5, 16'h0);
    @(negedge clk);
    chk("cleared_valid", rv0, 1);
    chk("cleared_data", rd0, 16'h0000);
    @(posedge clk); #1;

    req(0, 1, 10'h3FF, 16'h1234);
    req(0, 0, 10'h3FF, 16'h0);
    @(negedge clk);
    chk("wr_rd_valid", rv0, 1);
    chk("wr_rd_data", rd0, 16'h1234);
    chk("wr_rd_rsp1_quiet", rv1, 0);
    @(posedge clk); #1;

    // Contention: port 1 was served last, so port 0 wins the first tie.
    req(0, 1, 10'h010, 16'hAAAA);
    req(1, 1, 10'h020, 16'h5555);
    v0 = 1; we0 = 0; a0 = 10'h010;
    v1 = 1; we1 = 0; a1 = 10'h020;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_ready0", rdy0, (i % 2 == 0));
      chk("cont_ready1", rdy1, (i % 2 == 1));
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          chk("cont_rsp0_valid", rv0, 1);
          chk("cont_rsp0_data", rd0, 16'hAAAA);
          chk("cont_rsp1_idle", rv1, 0);
        end else begin
          chk("cont_rsp1_valid", rv1, 1);
          chk("cont_rsp1_data", rd1, 16'h5555);
          chk("cont_rsp0_idle", rv0, 0);
        end
      end
      @(posedge clk); #1;
    end
    v0 = 0;
    v1 = 0;
    @(negedge clk);
    chk("cont_last_rsp1_valid", rv1, 1);
    chk("cont_last_rsp1_data", rd1, 16'h5555);
    chk("cont_last_rsp0_idle", rv0, 0);
    @(posedge clk); #1;

    v1 = 1; we1 = 0; a1 = sa[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) chk("single_ready1", rdy1, 1);
      if (i > 0) begin
        chk("single_rsp1_valid", rv1, 1);
        chk("single_rsp1_data", rd1, sd[i-1]);
      end
      @(posedge clk); #1;
      if (i < 2) a1 = sa[i+1];
      else v1 = 0;
    end

    // Reset in the cycle after a read accept drops the pending strobe next cycle.
    req(0, 0, 10'h010, 16'h0);
    rst = 1;
    @(negedge clk);
    chk("midop_rsp_before", rv0, 1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midop_rsp_dropped", rv0, 0);
    chk("midop_busy", busy, 1);
    @(posedge clk); #1;
    v1 = 1; we1 = 1; a1 = 10'd7; wd1 = 16'h7777;
    count_busy(n);
    v1 = 0;
    chk("midop_clear_rest", n, 1023);
    req(1, 0, 10'd7, 16'h0);
    @(negedge clk);
    chk("midop_post_valid", rv1, 1);
    chk("midop_post_data", rd1, 16'h7777);
    @(posedge clk); #1;
    req(1, 0, 10'h020, 16'h0);
    @(negedge clk);
    chk("midop_cleared_data", rd1, 16'h0000);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    nc_v1 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("nc_reset_busy", nc_busy, 0);
    chk("nc_reset_ready1", nc_rdy1, 0);
    chk("nc_reset_rsp1", nc_rv1, 0);
    @(posedge clk); #1;
    nc_rst = 0;
    @(negedge clk);
    chk("nc_busy", nc_busy, 0);
    chk("nc_first_ready1", nc_rdy1, 1);
    chk("nc_ready0_idle", nc_rdy0, 0);
    @(posedge clk); #1;
    nc_v1 = 0;
    @(negedge clk);
    chk("nc_rsp1_valid", nc_rv1, 1);
    chk("nc_rsp0_idle", nc_rv0, 0);
    @(negedge clk);
    chk("nc_rsp1_single", nc_rv1, 0);
  end

endmodule
